// File: rtl/prime_number_pkg.sv
// Shared constants and types for the prime sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a (the block has no handshake).
package prime_number_pkg;

  // Candidate width exposed on the ports (0..2047).
  localparam int N_W     = 11;

  // One extra counter bit, so the sweep can step past 2047 and then stop
  // instead of wrapping back to 0.
  localparam int CNT_W   = 12;

  // Trial divisors: every prime up to floor(sqrt(2047)) = 45, i.e. up to 43.
  localparam int NUM_DIV = 14;
  localparam int DIVISORS [NUM_DIV] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43};

  typedef logic [N_W-1:0]   num_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/prime_check.sv
// Combinational primality test of a 12-bit candidate by constant-divisor trial division.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the result follows the input continuously.
module prime_check
  import prime_number_pkg::*;
(
  input  logic [CNT_W-1:0] n,
  output logic             is_prime
);

  // One flag per table divisor p: set when p divides n and p*p <= n.
  // The p*p <= n guard matters: without it n = p itself would look composite.
  logic [NUM_DIV-1:0] div_hit;

  for (genvar i = 0; i < NUM_DIV; i++) begin : g_div
    localparam logic [CNT_W-1:0] P    = CNT_W'(DIVISORS[i]);
    localparam logic [CNT_W-1:0] P_SQ = CNT_W'(DIVISORS[i] * DIVISORS[i]);

    // Each modulo has a constant right-hand side, so it reduces to fixed logic.
    assign div_hit[i] = (n >= P_SQ) && ((n % P) == '0);
  end

  // 0 and 1 are not prime; everything else is prime unless a divisor hit.
  assign is_prime = (n >= CNT_W'(2)) && (div_hit == '0);

endmodule

// File: rtl/prime_number.sv
// Sweeps candidates 0..numMax one per clock, reporting each candidate, its primality and a running prime count.
// Latency: candidate k appears on the outputs after the (k+1)th rising edge following reset release.
// Backpressure: none; the sweep stops once the counter passes numMax and resumes if numMax is raised.
module prime_number
  import prime_number_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] numMax,
  output logic           prime,
  output logic [N_W-1:0] numberChecked,
  output logic [N_W-1:0] numberOfPrimes
);

  // Next candidate to test. It is one bit wider than the outputs so that,
  // after 2047, it rests at 2048 (> any numMax) and the sweep cannot restart.
  cnt_t cnt;

  // Primality of the candidate currently held in cnt.
  logic cand_prime;

  // High while the current candidate is still inside the requested range.
  // numMax is read live, so a change takes effect on the very next edge.
  logic advance;

  assign advance = (cnt <= {1'b0, numMax});

  prime_check u_prime_check (
    .n        (cnt),
    .is_prime (cand_prime)
  );

  // Counter and output registers advance together, so prime and numberOfPrimes
  // always describe the same candidate as numberChecked; everything holds when done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      numberChecked  <= '0;
      prime          <= 1'b0;
      numberOfPrimes <= '0;
    end else if (advance) begin
      cnt            <= cnt + 1'b1;
      numberChecked  <= cnt[N_W-1:0];
      prime          <= cand_prime;
      numberOfPrimes <= numberOfPrimes + N_W'(cand_prime);
    end
  end

endmodule

// File: tb/tb_prime_number.sv
// Scoreboard bench for prime_number: expected outputs are queued per clock edge, and a monitor compares them.
// Reference primality is full trial division; spec-quoted constants are queued at the key points.
module tb_prime_number;

  logic        clk;
  logic        rst;
  logic [10:0] numMax;
  logic        prime;
  logic [10:0] numberChecked;
  logic [10:0] numberOfPrimes;

  prime_number dut (
    .clk            (clk),
    .rst            (rst),
    .numMax         (numMax),
    .prime          (prime),
    .numberChecked  (numberChecked),
    .numberOfPrimes (numberOfPrimes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int p;
    int c;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  event chk_now;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: next candidate, and the visible outputs.
  int m_cnt, m_chk, m_prime, m_count;

  localparam int TAG_MODEL   = 0;
  localparam int TAG_RESET   = 1;
  localparam int TAG_SPEC    = 2;
  localparam int TAG_PATTERN = 3;
  localparam int TAG_P2039   = 4;

  function automatic string tag_name(input int t);
    case (t)
      TAG_MODEL:   return "model_trace";
      TAG_RESET:   return "reset_clear";
      TAG_SPEC:    return "spec_final";
      TAG_PATTERN: return "pattern_0_10";
      TAG_P2039:   return "prime_2039";
      default:     return "unknown";
    endcase
  endfunction

  // Plain trial division by every integer, not only by the table primes.
  function automatic int ref_is_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 0;
    return 1;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_chk = 0; m_prime = 0; m_count = 0;
  endfunction

  // One rising edge of the behaviour described for the block.
  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else if (m_cnt <= int'(numMax)) begin
      m_chk   = m_cnt;
      m_prime = ref_is_prime(m_cnt);
      m_count = m_count + m_prime;
      m_cnt   = m_cnt + 1;
    end
  endfunction

  function automatic void push(input int n, input int p, input int c, input int tag);
    exp_t e;
    e.n = n; e.p = p; e.c = c; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(numberChecked) != e.n || int'(prime) != e.p || int'(numberOfPrimes) != e.c) begin
          failures++;
          $display("FAIL %s t=%0t: got numberChecked=%0d prime=%0d numberOfPrimes=%0d, required %0d/%0d/%0d",
                   tag_name(e.tag), $time, numberChecked, prime, numberOfPrimes, e.n, e.p, e.c);
        end
      end
    end
  end

  // Watchdog: the bench must end by itself.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Every tick returns at negedge+1, so input changes never race the monitor or the clock.
  task automatic tick();
    @(posedge clk);
    model_edge();
    push(m_chk, m_prime, m_count, TAG_MODEL);
    @(negedge clk);
    #1;
  endtask

  task automatic tick_expect(input int n, input int p, input int c, input int tag);
    @(posedge clk);
    model_edge();
    push(n, p, c, tag);
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset between edges: outputs must clear immediately.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    push(0, 0, 0, TAG_RESET);
    ->chk_now;
    #1;
    tick();
    rst = 1'b1;
  endtask

  int pat [11];
  int cum [11];

  initial begin
    pat = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0};
    cum = '{0, 0, 1, 2, 2, 3, 3, 4, 4, 4, 4};

    // Reset held for two cycles, then a sweep to 100.
    rst    = 1'b0;
    numMax = 11'd100;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    push(0, 0, 0, TAG_RESET);
    ->chk_now;
    #1;
    rst = 1'b1;
    repeat (100) tick();
    tick_expect(100, 0, 25, TAG_SPEC);
    repeat (5) tick();
    tick_expect(100, 0, 25, TAG_SPEC);

    // Per-edge prime pattern for 0..10.
    numMax = 11'd10;
    do_reset();
    for (int k = 0; k < 11; k++) tick_expect(k, pat[k], cum[k], TAG_PATTERN);
    repeat (3) tick();
    tick_expect(10, 0, 4, TAG_SPEC);

    // Small bounds.
    numMax = 11'd0;
    do_reset();
    tick_expect(0, 0, 0, TAG_SPEC);
    repeat (3) tick();
    numMax = 11'd1;
    do_reset();
    tick();
    tick_expect(1, 0, 0, TAG_SPEC);
    repeat (2) tick();
    numMax = 11'd2;
    do_reset();
    repeat (2) tick();
    tick_expect(2, 1, 1, TAG_SPEC);
    repeat (3) tick();
    tick_expect(2, 1, 1, TAG_SPEC);

    // Reset mid-sweep at candidate 20, then a full restart to 50.
    numMax = 11'd50;
    do_reset();
    repeat (21) tick();
    do_reset();
    repeat (50) tick();
    tick_expect(50, 0, 15, TAG_SPEC);
    repeat (3) tick();

    // Lower the bound mid-sweep, then raise it again after done.
    numMax = 11'd100;
    do_reset();
    while (m_chk != 40) tick();
    numMax = 11'd30;
    repeat (3) tick();
    tick_expect(40, 0, 12, TAG_SPEC);
    numMax = 11'd50;
    while (m_cnt != 50) tick();
    tick_expect(50, 0, 15, TAG_SPEC);
    repeat (2) tick();

    // Randomised bounds with occasional live changes of numMax.
    for (int ph = 0; ph < 6; ph++) begin
      numMax = 11'($urandom_range(0, 400));
      do_reset();
      for (int k = 0; k < 450; k++) begin
        if ($urandom_range(0, 49) == 0) numMax = 11'($urandom_range(0, 400));
        tick();
      end
    end

    // Full-width sweep: the counter must stop at 2047 rather than wrap.
    numMax = 11'd2047;
    do_reset();
    while (m_cnt != 2039) tick();
    tick_expect(2039, 1, 309, TAG_P2039);
    repeat (7) tick();
    tick_expect(2047, 0, 309, TAG_SPEC);
    repeat (5) tick();
    tick_expect(2047, 0, 309, TAG_SPEC);

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
